// File: rtl/cpu6502_pkg.sv
// Shared 6502 datapath definitions.
// Holds the PC sequencer state type and the hardware vector addresses so the
// PC stage and the interrupt sequencer agree on them.
package cpu6502_pkg;

  typedef enum logic [1:0] {
    VEC_LO = 2'd0,
    VEC_HI = 2'd1,
    RUN    = 2'd2
  } pc_state_t;

  localparam logic [15:0] RST_VEC = 16'hFFFC;
  localparam logic [15:0] NMI_VEC = 16'hFFFA;
  localparam logic [15:0] IRQ_VEC = 16'hFFFE;

endpackage

// File: rtl/pc_increment_unit_if.sv
// Control, bus and vector-fetch signals of the program-counter stage.
// master: the sequencer/decoder side that drives controls and vector data.
// slave : the PC stage itself.
interface pc_increment_unit_if;
  import cpu6502_pkg::*;

  // datapath controls
  logic        PCL_SEL_ADL;
  logic        PCH_SEL_ADH;
  logic        PC_LOAD;
  logic        PC_INC;
  logic [7:0]  ADL_DATA;
  logic [7:0]  ADH_DATA;
  // bus output enables
  logic        PCL_DB_EN;
  logic        PCL_ADL_EN;
  logic        PCH_DB_EN;
  logic        PCH_ADH_EN;
  // bus outputs
  logic [7:0]  DB_OUT;
  logic [7:0]  ADL_OUT;
  logic [7:0]  ADH_OUT;
  logic [15:0] PC_OUT;
  logic        PCL_CARRY;
  // reset-vector fetch
  logic        VEC_REQ;
  logic [15:0] VEC_ADDR;
  logic        VEC_ACK;
  logic [7:0]  VEC_DATA;
  logic        READY;

  modport master (
    output PCL_SEL_ADL, PCH_SEL_ADH, PC_LOAD, PC_INC, ADL_DATA, ADH_DATA,
    output PCL_DB_EN, PCL_ADL_EN, PCH_DB_EN, PCH_ADH_EN,
    output VEC_ACK, VEC_DATA,
    input  DB_OUT, ADL_OUT, ADH_OUT, PC_OUT, PCL_CARRY,
    input  VEC_REQ, VEC_ADDR, READY
  );

  modport slave (
    input  PCL_SEL_ADL, PCH_SEL_ADH, PC_LOAD, PC_INC, ADL_DATA, ADH_DATA,
    input  PCL_DB_EN, PCL_ADL_EN, PCH_DB_EN, PCH_ADH_EN,
    input  VEC_ACK, VEC_DATA,
    output DB_OUT, ADL_OUT, ADH_OUT, PC_OUT, PCL_CARRY,
    output VEC_REQ, VEC_ADDR, READY
  );

endinterface

// File: rtl/pc_inc8.sv
// One byte of the PC incrementer: source mux followed by a +carry-in adder.
// Ports:
//   i_sel  - 1 selects i_ext (bus), 0 selects i_reg (register loop)
//   i_ext  - external bus byte
//   i_reg  - current register byte
//   i_cin  - carry / increment input
//   o_sum  - (selected byte + i_cin) mod 256
//   o_cout - carry out of the byte
module pc_inc8 (
  input  logic       i_sel,
  input  logic [7:0] i_ext,
  input  logic [7:0] i_reg,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);

  logic [7:0] w_src;

  assign w_src           = i_sel ? i_ext : i_reg;
  assign {o_cout, o_sum} = {1'b0, w_src} + {8'd0, i_cin};

endmodule

// File: rtl/pc_increment_unit.sv
// 6502 program-counter stage: PCLS/PCHS source select, increment with
// low-to-high carry, PCL/PCH storage, bus drivers, and a reset-vector loader
// that fetches the start address before honouring datapath controls.
// Ports:
//   CLK   - system clock, rising edge
//   RST_N - asynchronous active-low reset
//   bus   - slave modport carrying controls, bus enables/outputs and the
//           vector-fetch handshake (VEC_REQ/VEC_ADDR/VEC_ACK/VEC_DATA/READY)
module pc_increment_unit
  import cpu6502_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = RST_VEC,
  parameter logic [15:0] RESET_PC     = 16'h0000
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  pc_increment_unit_if.slave   bus
);

  pc_state_t  r_state;
  pc_state_t  w_state_nxt;
  logic [7:0] r_pcl;
  logic [7:0] r_pch;
  logic       r_carry;

  logic [7:0] w_pcl_d;
  logic [7:0] w_pch_d;
  logic       w_carry_d;
  logic [7:0] w_lo_next;
  logic [7:0] w_hi_next;
  logic       w_lo_cout;
  logic       w_hi_cout_unused;

  pc_inc8 u_inc_lo (
    .i_sel  (bus.PCL_SEL_ADL),
    .i_ext  (bus.ADL_DATA),
    .i_reg  (r_pcl),
    .i_cin  (bus.PC_INC),
    .o_sum  (w_lo_next),
    .o_cout (w_lo_cout)
  );

  // High byte only ever adds the low-byte carry; its own carry-out is the
  // silent 16-bit wrap FFFF -> 0000.
  pc_inc8 u_inc_hi (
    .i_sel  (bus.PCH_SEL_ADH),
    .i_ext  (bus.ADH_DATA),
    .i_reg  (r_pch),
    .i_cin  (w_lo_cout),
    .o_sum  (w_hi_next),
    .o_cout (w_hi_cout_unused)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= VEC_LO;
      r_pcl   <= RESET_PC[7:0];
      r_pch   <= RESET_PC[15:8];
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pcl   <= w_pcl_d;
      r_pch   <= w_pch_d;
      r_carry <= w_carry_d;
    end
  end

  // Vector bytes land directly in PCL/PCH; datapath controls only act in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_pcl_d     = r_pcl;
    w_pch_d     = r_pch;
    w_carry_d   = 1'b0;
    unique case (r_state)
      VEC_LO: begin
        if (bus.VEC_ACK) begin
          w_pcl_d     = bus.VEC_DATA;
          w_state_nxt = VEC_HI;
        end
      end
      VEC_HI: begin
        if (bus.VEC_ACK) begin
          w_pch_d     = bus.VEC_DATA;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.PC_LOAD) begin
          w_pcl_d   = w_lo_next;
          w_pch_d   = w_hi_next;
          // Low carry can only be set when PC_INC=1 and the source was FF.
          w_carry_d = w_lo_cout;
        end
      end
      default: w_state_nxt = VEC_LO;
    endcase
  end

  assign bus.PC_OUT    = {r_pch, r_pcl};
  assign bus.PCL_CARRY = r_carry;
  assign bus.READY     = (r_state == RUN);
  // Request is suppressed while reset is asserted even though the state
  // register already sits in VEC_LO.
  assign bus.VEC_REQ   = RST_N && (r_state != RUN);
  // VEC_HI and RUN both present the high-byte address, so RUN holds it.
  assign bus.VEC_ADDR  = (r_state == VEC_LO) ? RESET_VECTOR
                                             : RESET_VECTOR + 16'd1;

  // Bus drivers stay quiet during reset regardless of the enables.
  assign bus.DB_OUT  = !RST_N         ? 8'h00 :
                       bus.PCL_DB_EN  ? r_pcl :
                       bus.PCH_DB_EN  ? r_pch : 8'h00;
  assign bus.ADL_OUT = (RST_N && bus.PCL_ADL_EN) ? r_pcl : 8'h00;
  assign bus.ADH_OUT = (RST_N && bus.PCH_ADH_EN) ? r_pch : 8'h00;

endmodule

// File: doc/pc_increment_unit.md
Name: pc_increment_unit

Overview:
- Program-counter stage of the 6502 datapath: PCLS/PCHS source select, increment logic with low-to-high carry, and PCL/PCH storage.
- Feeds the PCL/PCH bus drivers (DB, ADL, ADH) and the address-bus mux.
- Includes a reset-vector loader that fetches the start address from the vector pair before normal operation.

Parameters:
- RESET_VECTOR, 16'hFFFC, address of vector low byte; high byte is RESET_VECTOR+1.
- RESET_PC, 16'h0000, PC value held while in reset and until the vector is loaded.

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- RST_N  in  1  asynchronous active-low reset
- PCL_SEL_ADL  in  1  PCLS takes ADL_DATA (else PCL loop)
- PCH_SEL_ADH  in  1  PCHS takes ADH_DATA (else PCH loop)
- PC_LOAD  in  1  write selected/incremented value into PCL/PCH this cycle
- PC_INC  in  1  I/PC: add 1 to selected value before writing
- ADL_DATA  in  8  ADL bus input
- ADH_DATA  in  8  ADH bus input
- PCL_DB_EN, PCL_ADL_EN, PCH_DB_EN, PCH_ADH_EN  in  1 each  bus output enables
- DB_OUT  out  8  PCL or PCH onto DB
- ADL_OUT  out  8  PCL onto ADL
- ADH_OUT  out  8  PCH onto ADH
- PC_OUT  out  16  current {PCH,PCL}
- PCL_CARRY  out  1  one-cycle pulse: increment wrapped PCL FF->00
- VEC_REQ  out  1  vector-fetch read request
- VEC_ADDR  out  16  vector byte address
- VEC_ACK  in  1  vector read data valid on VEC_DATA
- VEC_DATA  in  8  vector byte
- READY  out  1  vector loaded; control inputs honoured

Behaviour:
- Reset (RST_N=0, async): PCL/PCH = RESET_PC, state=VEC_LO, PCL_CARRY=0, READY=0, VEC_REQ=0, VEC_ADDR=RESET_VECTOR, all bus outputs 8'h00. Reset mid-fetch or mid-run aborts immediately.
- FSM states VEC_LO -> VEC_HI -> RUN; RUN is terminal until reset.
- VEC_LO: VEC_REQ=1, VEC_ADDR=RESET_VECTOR; on CLK with VEC_ACK=1, PCL<=VEC_DATA, go VEC_HI.
- VEC_HI: VEC_REQ=1, VEC_ADDR=RESET_VECTOR+1; on VEC_ACK=1, PCH<=VEC_DATA, go RUN.
- Without VEC_ACK, state holds indefinitely; VEC_REQ stays 1.
- RUN: VEC_REQ=0, READY=1, VEC_ADDR holds last value.
- Outside RUN: PC_LOAD, PC_INC and PCL_CARRY ignored/forced 0. Bus enables are still honoured, so the partially loaded PC is visible.
- Source select (combinational): lo_src = PCL_SEL_ADL ? ADL_DATA : PCL; hi_src = PCH_SEL_ADH ? ADH_DATA : PCH.
- Increment: {c,lo_next} = lo_src + PC_INC; hi_next = hi_src + c, 8-bit modulo.
- 16'hFFFF+1 = 16'h0000 with no extra flag beyond PCL_CARRY.
- Latency: on CLK with PC_LOAD=1 in RUN, PCL<=lo_next, PCH<=hi_next; visible on PC_OUT next cycle. PC_LOAD=0 holds PC regardless of PC_INC or selects.
- PCL_CARRY: registered; 1 for exactly the cycle after a load where PC_INC=1 and lo_src=8'hFF, else 0.
- Bus outputs (combinational from registers):
  - DB_OUT: PCL_DB_EN has priority over PCH_DB_EN; 8'h00 if neither is set.
  - ADL_OUT: PCL when PCL_ADL_EN, else 8'h00.
  - ADH_OUT: PCH when PCH_ADH_EN, else 8'h00.
- Selects and enables may change every cycle; no handshake on datapath controls.

Decomposition:
- Shared package cpu6502_pkg:
  - pc_state_t enum {VEC_LO, VEC_HI, RUN}
  - constants RST_VEC=16'hFFFC, NMI_VEC=16'hFFFA, IRQ_VEC=16'hFFFE for later reuse by the interrupt sequencer
- One sub-module, pc_inc8: 8-bit source mux plus +cin adder with carry-out, instantiated twice (low byte cin=PC_INC, high byte cin=low carry).

Test Plan:
- Reset release, VEC_ACK held 1 with VEC_DATA=8'h34 then 8'h12 -> VEC_ADDR FFFC then FFFD, PC_OUT=16'h1234, READY=1 on the third cycle, VEC_REQ=0.
- In RUN at PC=16'h12FF, PC_LOAD=1, PC_INC=1, no selects -> PC_OUT=16'h1300, PCL_CARRY=1 for one cycle, then 0.
- PC=16'hFFFF, increment -> PC_OUT=16'h0000, PCL_CARRY=1.
- PCL_SEL_ADL=1, PCH_SEL_ADH=1, ADL_DATA=8'h80, ADH_DATA=8'hC0, PC_INC=0, PC_LOAD=1 -> PC_OUT=16'hC080. Repeat with PC_INC=1 -> 16'hC081.
- VEC_ACK withheld 10 cycles in VEC_LO with PC_LOAD/PC_INC toggling -> PC_OUT stays RESET_PC, VEC_REQ=1 throughout. RST_N pulsed low while in VEC_HI -> state VEC_LO, PC=RESET_PC asynchronously.
- PCL_DB_EN and PCH_DB_EN both 1 at PC=16'hAB12 -> DB_OUT=8'h12; PCH_ADH_EN=1 -> ADH_OUT=8'hAB; all enables 0 -> all bus outputs 8'h00.
